random_range_gen: RTL

- Parametrised successor to the fixed 3-bit LFSR address generator.
- Produces uniformly distributed values in 0..RANGE-1 on demand through a request/valid handshake.
- Uses rejection sampling over a configurable-length Fibonacci LFSR. Reseeds from a free-running entropy counter when the game/user strobes `seed_load`.
- Feeds game sequencers, memory-address pickers and similar consumers.

---
 rtl/random_pkg.sv | 33 +++
 rtl/random_range_gen_lfsr.sv | 33 +++
 rtl/random_range_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/random_pkg.sv
// rtl/random_pkg.sv - shared LFSR tap table and FSM state encoding for random_range_gen
package random_pkg;

    // Feedback taps for the 16-bit register: bits 15, 13, 12 and 10
    localparam logic [15:0] TAP_MASK_16 = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Maximal-length tap masks for a shift-left Fibonacci LFSR, indexed by length
    function automatic logic [15:0] tap_mask(input int size);
        case (size)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return TAP_MASK_16;
        endcase
    endfunction

endpackage

// File: rtl/random_range_gen_lfsr.sv
// rtl/random_range_gen_lfsr.sv - lfsr_core: loadable shift-left Fibonacci LFSR
module lfsr_core
    import random_pkg::*;
#(
    parameter int                    LFSR_SIZE = 16,
    parameter logic [LFSR_SIZE-1:0] TAP_MASK  = LFSR_SIZE'(tap_mask(LFSR_SIZE))
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [LFSR_SIZE-1:0] load_value,
    input  logic                 shift_en,
    output logic [LFSR_SIZE-1:0] state
);

    logic [LFSR_SIZE-1:0] r_state;
    logic                 w_feedback;

    assign w_feedback = ^(r_state & TAP_MASK);
    assign state      = r_state;

    // Load has priority over shifting; all-ones reset keeps the register out of the lock-up state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= '1;
        end else if (load) begin
            r_state <= load_value;
        end else if (shift_en) begin
            r_state <= {r_state[LFSR_SIZE-2:0], w_feedback};
        end
    end

endmodule

// File: rtl/random_range_gen.sv
// rtl/random_range_gen.sv - uniform 0..RANGE-1 draws by LFSR rejection sampling; RANDOM_NO_REPEAT_EN forbids consecutive repeats
module random_range_gen
    import random_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter int RANGE          = 8,
    parameter int LFSR_SIZE      = 16,
    parameter int STEPS_PER_DRAW = 3,
    parameter int MAX_RETRY      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seed_load,
    input  logic             request,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic             fallback
);

    localparam int                   WP1         = WIDTH + 1;
    localparam logic [LFSR_SIZE-1:0] TAPS        = LFSR_SIZE'(tap_mask(LFSR_SIZE));
    localparam logic [WIDTH:0]       RANGE_EXT   = WP1'(RANGE);
    localparam logic [WIDTH-1:0]     RANGE_W     = WIDTH'(RANGE);
    localparam logic [3:0]           MAX_RETRY_W = 4'(MAX_RETRY);
    localparam logic [4:0]           STEP_LAST   = 5'(STEPS_PER_DRAW - 1);

    state_t               r_state;
    logic [4:0]           r_step;
    logic [3:0]           r_retry;
    logic [WIDTH-1:0]     r_value;
    logic                 r_valid;
    logic                 r_fallback;
    logic                 r_ready;
    logic [LFSR_SIZE-1:0] r_entropy;

    logic [LFSR_SIZE-1:0] w_lfsr;
    logic [LFSR_SIZE-1:0] w_seed;
    logic                 w_shift_en;
    logic [WIDTH-1:0]     w_cand;
    logic                 w_in_range;
    logic                 w_reject;
    logic [3:0]           w_retry_inc;
    logic                 w_give_up;
    logic                 w_finish;
    logic [WIDTH-1:0]     w_fallback_val;
    logic [WIDTH-1:0]     w_out_val;
    logic                 w_unused_lfsr_hi;

    assign ready    = r_ready;
    assign valid    = r_valid;
    assign value    = r_value;
    assign fallback = r_fallback;

    // Forcing the LSB keeps a zero counter value from seeding the lock-up state
    assign w_seed     = r_entropy | {{(LFSR_SIZE-1){1'b0}}, 1'b1};
    assign w_shift_en = (r_state == SHIFT);

    lfsr_core #(
        .LFSR_SIZE (LFSR_SIZE),
        .TAP_MASK  (TAPS)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (seed_load),
        .load_value (w_seed),
        .shift_en   (w_shift_en),
        .state      (w_lfsr)
    );

    // Only the low WIDTH bits form the candidate; the rest only feed the shift chain
    assign w_cand           = w_lfsr[WIDTH-1:0];
    assign w_unused_lfsr_hi = ^w_lfsr[LFSR_SIZE-1:WIDTH];
    assign w_in_range       = ({1'b0, w_cand} < RANGE_EXT);
    assign w_retry_inc      = r_retry + 4'd1;
    assign w_give_up        = w_reject && (w_retry_inc == MAX_RETRY_W);
    assign w_finish         = (r_state == CHECK) && !seed_load && (!w_reject || w_give_up);
    assign w_out_val        = w_reject ? w_fallback_val : w_cand;

`ifdef RANDOM_NO_REPEAT_EN
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(RANGE - 1);

    logic             r_have_last;
    logic [WIDTH-1:0] r_last;
    logic             w_repeat;
    logic [WIDTH-1:0] w_folded;
    logic [WIDTH-1:0] w_last_next;

    // A repeat can be rejected while in range, so only out-of-range candidates are folded
    assign w_repeat       = r_have_last && (w_cand == r_last);
    assign w_reject       = !w_in_range || w_repeat;
    assign w_folded       = w_in_range ? w_cand : (w_cand - RANGE_W);
    assign w_last_next    = (r_last == MAX_VAL) ? '0 : (r_last + 1'b1);
    assign w_fallback_val = (r_have_last && (w_folded == r_last)) ? w_last_next : w_folded;

    // Remember the most recently delivered value; reseeding forgets it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_have_last <= 1'b0;
            r_last      <= '0;
        end else if (seed_load) begin
            r_have_last <= 1'b0;
        end else if (w_finish) begin
            r_have_last <= 1'b1;
            r_last      <= w_out_val;
        end
    end
`else
    // The RANGE constraint keeps candidate - RANGE inside 0..RANGE-1
    assign w_reject       = !w_in_range;
    assign w_fallback_val = w_cand - RANGE_W;
`endif

    // Free-running entropy source sampled by seed_load
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_entropy <= '0;
        end else begin
            r_entropy <= r_entropy + 1'b1;
        end
    end

    // Draw sequencer: shift, test candidate, retry or fall back, then pulse valid for one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_retry    <= '0;
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
            if (seed_load) begin
                r_state <= IDLE;
                r_step  <= '0;
                r_retry <= '0;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (request) begin
                            r_state <= SHIFT;
                            r_step  <= '0;
                            r_ready <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (r_step == STEP_LAST) begin
                            r_state <= CHECK;
                        end else begin
                            r_step <= r_step + 5'd1;
                        end
                    end
                    CHECK: begin
                        if (w_finish) begin
                            r_value    <= w_out_val;
                            r_fallback <= w_reject;
                            r_valid    <= 1'b1;
                            r_ready    <= 1'b1;
                            r_state    <= DONE;
                            if (w_reject) begin
                                r_retry <= w_retry_inc;
                            end
                        end else begin
                            r_retry <= w_retry_inc;
                            r_step  <= '0;
                            r_state <= SHIFT;
                        end
                    end
                    default: begin
                        r_retry <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
